// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer: frame counter with end-of-frame strobes, 12-step
// commutation index and a ramped pulse length. Optional MOTORO3_SEQ_FREEWHEEL_EN blanks plLen in steps 7..10.
module motoro3_step_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        runReq,
    input  logic        dirRev,
    input  logic [24:0] m3r_frameLen,
    input  logic [15:0] m3r_plLenTarget,
    input  logic [15:0] m3r_rampStep,
    output logic [24:0] m3cnt,
    output logic        m3cntLast2,
    output logic        m3cntLast1,
    output logic [3:0]  sgStep,
    output logic [15:0] plLen,
    output logic [1:0]  seqState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } seq_state_t;

    seq_state_t  state, stateNext;
    logic [24:0] frameLenQ, frameLenNext, frameLenClamped, cntNext;
    logic [15:0] rampVal, rampNext, rampToward, rampDown;
    logic [16:0] rampSum;
    logic [3:0]  sgNext;
    logic        stopPend, stopPendNext, last2Next, last1Next, frameEnd, freewheel;

    assign frameLenClamped = (m3r_frameLen < 25'd4) ? 25'd4 : m3r_frameLen;
    assign frameEnd        = (state != IDLE) && m3cntLast1;
    assign seqState        = state;

    // rampStep of 0 means jump straight to the destination value.
    always_comb begin
        rampSum    = {1'b0, rampVal} + {1'b0, m3r_rampStep};
        rampToward = m3r_plLenTarget;
        if (m3r_rampStep != 16'd0) begin
            if (rampVal < m3r_plLenTarget)
                rampToward = (rampSum >= {1'b0, m3r_plLenTarget}) ? m3r_plLenTarget : rampSum[15:0];
            else if (rampVal > m3r_plLenTarget)
                rampToward = ((rampVal - m3r_plLenTarget) <= m3r_rampStep) ? m3r_plLenTarget
                                                                           : rampVal - m3r_rampStep;
        end
        rampDown = ((m3r_rampStep == 16'd0) || (rampVal <= m3r_rampStep)) ? 16'd0
                                                                          : rampVal - m3r_rampStep;
    end

    always_comb begin
        stateNext    = state;
        rampNext     = rampVal;
        sgNext       = sgStep;
        frameLenNext = frameLenQ;
        cntNext      = m3cnt;
        stopPendNext = stopPend;
        case (state)
            IDLE: begin
                cntNext      = 25'd0;
                stopPendNext = 1'b0;
                if (runReq) begin
                    stateNext    = RAMP;
                    frameLenNext = frameLenClamped;
                end
            end
            default: begin
                cntNext = m3cnt + 25'd1;
                if (!runReq && state != STOP)
                    stopPendNext = 1'b1;
                if (frameEnd) begin
                    cntNext      = 25'd0;
                    frameLenNext = frameLenClamped;
                    stopPendNext = 1'b0;
                    if (dirRev)
                        sgNext = (sgStep == 4'd0) ? 4'd11 : sgStep - 4'd1;
                    else
                        sgNext = (sgStep == 4'd11) ? 4'd0 : sgStep + 4'd1;
                    case (state)
                        RAMP, RUN: begin
                            // A stop request seen anywhere in the frame wins over ramping.
                            if (stopPend || !runReq) begin
                                stateNext = STOP;
                            end else begin
                                rampNext = rampToward;
                                if (rampToward == m3r_plLenTarget)
                                    stateNext = RUN;
                            end
                        end
                        STOP: begin
                            if (runReq) begin
                                stateNext = RAMP;
                            end else begin
                                rampNext = rampDown;
                                if (rampDown == 16'd0)
                                    stateNext = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        last2Next = (stateNext != IDLE) && (cntNext == frameLenNext - 25'd2);
        last1Next = (stateNext != IDLE) && (cntNext == frameLenNext - 25'd1);
    end

`ifdef MOTORO3_SEQ_FREEWHEEL_EN
    assign freewheel = (sgNext >= 4'd7) && (sgNext <= 4'd10);
`else
    assign freewheel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m3cnt      <= 25'd0;
            m3cntLast2 <= 1'b0;
            m3cntLast1 <= 1'b0;
            sgStep     <= 4'd0;
            rampVal    <= 16'd0;
            plLen      <= 16'd0;
            frameLenQ  <= 25'd4;
            stopPend   <= 1'b0;
        end else begin
            state      <= stateNext;
            m3cnt      <= cntNext;
            m3cntLast2 <= last2Next;
            m3cntLast1 <= last1Next;
            sgStep     <= sgNext;
            rampVal    <= rampNext;
            plLen      <= freewheel ? 16'd0 : rampNext;
            frameLenQ  <= frameLenNext;
            stopPend   <= stopPendNext;
        end
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Self-checking bench for motoro3_step_sequencer: frame-end results are queued
// when stimulus is applied and compared when the frame-end strobe completes.
module tb_motoro3_step_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        runReq = 1'b0;
    logic        dirRev = 1'b0;
    logic [24:0] m3r_frameLen = 25'd10;
    logic [15:0] m3r_plLenTarget = 16'd0;
    logic [15:0] m3r_rampStep = 16'd0;
    logic [24:0] m3cnt;
    logic        m3cntLast2, m3cntLast1;
    logic [3:0]  sgStep;
    logic [15:0] plLen;
    logic [1:0]  seqState;

    localparam logic [1:0] S_IDLE = 2'd0, S_RAMP = 2'd1, S_RUN = 2'd2, S_STOP = 2'd3;

    int n_checks = 0;
    int n_fail = 0;
    logic [21:0] exp_q[$];

    motoro3_step_sequencer dut (
        .clk(clk), .rst(rst), .runReq(runReq), .dirRev(dirRev),
        .m3r_frameLen(m3r_frameLen), .m3r_plLenTarget(m3r_plLenTarget),
        .m3r_rampStep(m3r_rampStep), .m3cnt(m3cnt), .m3cntLast2(m3cntLast2),
        .m3cntLast1(m3cntLast1), .sgStep(sgStep), .plLen(plLen), .seqState(seqState)
    );

    // clock / reset
    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pl(input logic [3:0] sg, input logic [15:0] ramp);
`ifdef MOTORO3_SEQ_FREEWHEEL_EN
        if (sg >= 4'd7 && sg <= 4'd10) return 16'd0;
`endif
        return ramp;
    endfunction

    task automatic push_exp(input logic [1:0] st, input logic [3:0] sg, input logic [15:0] ramp);
        exp_q.push_back({st, sg, exp_pl(sg, ramp)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        runReq = 1'b0;
        dirRev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic frame_end_compare();
        logic [21:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("fe_state", 32'(seqState), 32'(e[21:20]));
            check_val("fe_sgStep", 32'(sgStep), 32'(e[19:16]));
            check_val("fe_plLen", 32'(plLen), 32'(e[15:0]));
            check_val("fe_m3cnt", 32'(m3cnt), 32'd0);
        end
    endtask

    task automatic wait_frame_end();
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m3cntLast1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("frame_timeout", 32'd0, 32'd1);
        else frame_end_compare();
    endtask

    task automatic check_frame_shape(input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check_val({tag, "_cnt"}, 32'(m3cnt), 32'(i));
            check_val({tag, "_last2"}, 32'(m3cntLast2), 32'(i == len - 2));
            check_val({tag, "_last1"}, 32'(m3cntLast1), 32'(i == len - 1));
        end
    endtask

    task automatic check_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_val({tag, "_state"}, 32'(seqState), 32'(S_IDLE));
            check_val({tag, "_cnt"}, 32'(m3cnt), 32'd0);
            check_val({tag, "_strobe"}, 32'({m3cntLast2, m3cntLast1}), 32'd0);
        end
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", 32'(seqState), 32'(S_IDLE));
        check_val("rst_cnt", 32'(m3cnt), 32'd0);
        check_val("rst_strobes", 32'({m3cntLast2, m3cntLast1}), 32'd0);
        check_val("rst_sgStep", 32'(sgStep), 32'd0);
        check_val("rst_plLen", 32'(plLen), 32'd0);

        // frameLen 10, ramp 100 -> 300, full step cycle
        @(negedge clk);
        rst = 1'b0;
        m3r_frameLen = 25'd10;
        m3r_plLenTarget = 16'd300;
        m3r_rampStep = 16'd100;
        runReq = 1'b1;
        for (int f = 1; f <= 13; f++)
            push_exp((f >= 3) ? S_RUN : S_RAMP, 4'(f % 12), (f <= 3) ? 16'(f * 100) : 16'd300);
        @(posedge clk);
        #1;
        check_val("start_state", 32'(seqState), 32'(S_RAMP));
        check_frame_shape(10, "f10");
        frame_end_compare();
        for (int f = 2; f <= 13; f++) wait_frame_end();

        // ramp down from 300 with step 128, then idle
        runReq = 1'b0;
        m3r_rampStep = 16'd128;
        push_exp(S_STOP, 4'd2, 16'd300);
        push_exp(S_STOP, 4'd3, 16'd172);
        push_exp(S_STOP, 4'd4, 16'd44);
        push_exp(S_IDLE, 4'd5, 16'd0);
        repeat (4) wait_frame_end();
        check_idle(5, "after_stop");

        // reverse from step 0, short frameLen, saturating ramp, zero-step jump
        do_reset();
        dirRev = 1'b1;
        m3r_frameLen = 25'd2;
        m3r_plLenTarget = 16'hFFFF;
        m3r_rampStep = 16'hFFFF;
        runReq = 1'b1;
        push_exp(S_RUN, 4'd11, 16'hFFFF);
        push_exp(S_RUN, 4'd10, 16'hFFFF);
        @(posedge clk);
        check_frame_shape(4, "f2as4");
        frame_end_compare();
        wait_frame_end();
        m3r_plLenTarget = 16'd500;
        m3r_rampStep = 16'd0;
        push_exp(S_RUN, 4'd9, 16'd500);
        push_exp(S_RUN, 4'd8, 16'd500);
        wait_frame_end();
        wait_frame_end();

        // STOP returns to RAMP without clearing the ramp value
        do_reset();
        m3r_frameLen = 25'd6;
        m3r_plLenTarget = 16'd300;
        m3r_rampStep = 16'd100;
        runReq = 1'b1;
        push_exp(S_RAMP, 4'd1, 16'd100);
        wait_frame_end();
        runReq = 1'b0;
        push_exp(S_STOP, 4'd2, 16'd100);
        wait_frame_end();
        runReq = 1'b1;
        push_exp(S_RAMP, 4'd3, 16'd100);
        push_exp(S_RAMP, 4'd4, 16'd200);
        wait_frame_end();
        wait_frame_end();

        // reset asserted mid-frame during RAMP
        do_reset();
        m3r_frameLen = 25'd10;
        runReq = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (seqState == S_RAMP && m3cnt == 25'd5) begin
                    hit = 1'b1;
                    break;
                end
            end
            check_val("midramp_reached", 32'(hit), 32'd1);
        end
        rst = 1'b1;
        runReq = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rst_state", 32'(seqState), 32'(S_IDLE));
        check_val("mid_rst_cnt", 32'(m3cnt), 32'd0);
        check_val("mid_rst_strobes", 32'({m3cntLast2, m3cntLast1}), 32'd0);
        check_val("mid_rst_sgStep", 32'(sgStep), 32'd0);
        check_val("mid_rst_plLen", 32'(plLen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_idle(8, "post_rst");

        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
